ahb_dls_monitor: RTL

AHB_DLS_MONITOR -- requirements
Module: ahb_dls_monitor

---
 rtl/ahb_dls_pkg.sv | 22 ++
 rtl/dls_voter.sv | 36 +++
 rtl/ahb_dls_monitor.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ahb_dls_pkg.sv
// Shared definitions for the display lockstep monitor: FSM states, register
// word offsets and fault-injection codes.
package ahb_dls_pkg;

    typedef enum logic [1:0] {
        ST_OK      = 2'd0,
        ST_SUSPECT = 2'd1,
        ST_ERROR   = 2'd2
    } dls_state_t;

    // Word offsets, decoded from HADDR[3:2]
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    localparam logic [4:0] INJ_NONE      = 5'd0;
    localparam logic [4:0] INJ_RGB0_BIT0 = 5'd1;
    localparam logic [4:0] INJ_HSYNC1    = 5'd2;
    localparam logic [4:0] INJ_MASK_ERR  = 5'd3;

endpackage

// File: rtl/dls_voter.sv
// Per-cycle replica comparison: picks replica 0 (lockstep) or the bitwise
// 2-of-3 majority (TMR), and flags every replica that differs from replica 0.
module dls_voter #(
    parameter int RGB_W    = 8,
    parameter int NUM_REPL = 2
) (
    input  logic [NUM_REPL-1:0]       hsync,
    input  logic [NUM_REPL-1:0]       vsync,
    input  logic [NUM_REPL*RGB_W-1:0] rgb,
    output logic                      hsync_sel,
    output logic                      vsync_sel,
    output logic [RGB_W-1:0]          rgb_sel,
    output logic [NUM_REPL-1:0]       mismatch_mask
);

    localparam int VEC_W = RGB_W + 2;

    logic [VEC_W-1:0] vec [NUM_REPL];
    logic [VEC_W-1:0] voted;

    for (genvar i = 0; i < NUM_REPL; i++) begin : g_vec
        assign vec[i]           = {hsync[i], vsync[i], rgb[i*RGB_W +: RGB_W]};
        assign mismatch_mask[i] = (vec[i] != vec[0]);
    end

    if (NUM_REPL == 3) begin : g_tmr
        assign voted = (vec[0] & vec[1]) | (vec[0] & vec[2]) | (vec[1] & vec[2]);
    end else begin : g_dmr
        assign voted = vec[0];
    end

    assign hsync_sel = voted[VEC_W-1];
    assign vsync_sel = voted[VEC_W-2];
    assign rgb_sel   = voted[RGB_W-1:0];

endmodule

// File: rtl/ahb_dls_monitor.sv
// Display lockstep monitor: compares replicated video streams, drives the
// selected/voted stream and exposes status, count and control over AHB-Lite.
module ahb_dls_monitor
    import ahb_dls_pkg::*;
#(
    parameter int RGB_W      = 8,
    parameter int NUM_REPL   = 2,
    parameter int ERR_THRESH = 1,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      HSEL,
    input  logic [31:0]               HADDR,
    input  logic [1:0]                HTRANS,
    input  logic                      HWRITE,
    input  logic [31:0]               HWDATA,
    input  logic                      HREADY,
    output logic                      HREADYOUT,
    output logic [31:0]               HRDATA,
    input  logic [NUM_REPL-1:0]       rep_hsync,
    input  logic [NUM_REPL-1:0]       rep_vsync,
    input  logic [NUM_REPL*RGB_W-1:0] rep_rgb,
    input  logic [4:0]                inject_bug,
    output logic                      HSYNC,
    output logic                      VSYNC,
    output logic [RGB_W-1:0]          RGB,
    output logic                      DLS_ERROR
);

    localparam logic [7:0]       THRESH8 = 8'(ERR_THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_REPL-1:0]       hsync_inj;
    logic [NUM_REPL*RGB_W-1:0] rgb_inj;
    logic                      hsync_sel;
    logic                      vsync_sel;
    logic [RGB_W-1:0]          rgb_sel;
    logic [NUM_REPL-1:0]       mask_p0;
    logic                      mismatch_p0;

    logic                      hsync_p1;
    logic                      vsync_p1;
    logic [RGB_W-1:0]          rgb_p1;
    logic [NUM_REPL-1:0]       mask_p1;

    dls_state_t                state;
    logic [7:0]                run;
    logic [7:0]                run_next;
    logic [CNT_W-1:0]          cnt;
    logic                      cmp_en;

    logic                      addr_phase;
    logic                      wr_q;
    logic                      rd_q;
    logic [1:0]                addr_q;
    logic                      ctrl_wr;
    logic                      clear_req;

    logic                      unused_ahb;

    assign unused_ahb = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:2]};

    // Fault injection sits in front of the comparison so the monitor sees it
    always_comb begin
        hsync_inj = rep_hsync;
        rgb_inj   = rep_rgb;
        if (inject_bug == INJ_RGB0_BIT0) rgb_inj[0]   = ~rep_rgb[0];
        if (inject_bug == INJ_HSYNC1)    hsync_inj[1] = ~rep_hsync[1];
    end

    dls_voter #(
        .RGB_W    (RGB_W),
        .NUM_REPL (NUM_REPL)
    ) u_voter (
        .hsync         (hsync_inj),
        .vsync         (rep_vsync),
        .rgb           (rgb_inj),
        .hsync_sel     (hsync_sel),
        .vsync_sel     (vsync_sel),
        .rgb_sel       (rgb_sel),
        .mismatch_mask (mask_p0)
    );

    assign mismatch_p0 = |mask_p0;

    // p0 -> p1: registered video and last-cycle mismatch mask
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync_p1 <= 1'b0;
            vsync_p1 <= 1'b0;
            rgb_p1   <= '0;
            mask_p1  <= '0;
        end else begin
            hsync_p1 <= hsync_sel;
            vsync_p1 <= vsync_sel;
            rgb_p1   <= rgb_sel;
            mask_p1  <= mask_p0;
        end
    end

    assign HSYNC = hsync_p1;
    assign VSYNC = vsync_p1;
    assign RGB   = rgb_p1;

    // AHB address phase capture; write data arrives one cycle later
    assign addr_phase = HSEL & HREADY & HTRANS[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            addr_q <= 2'd0;
        end else if (HREADY) begin
            wr_q   <= addr_phase & HWRITE;
            rd_q   <= addr_phase & ~HWRITE;
            addr_q <= addr_phase ? HADDR[3:2] : 2'd0;
        end
    end

    assign ctrl_wr   = wr_q & (addr_q == REG_CTRL);
    assign clear_req = ctrl_wr & HWDATA[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cmp_en <= 1'b1;
        else if (ctrl_wr) cmp_en <= HWDATA[1];
    end

    assign run_next = run + 8'd1;

    // Clear wins over a mismatch sampled in the same cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_OK;
            run   <= 8'd0;
        end else if (clear_req) begin
            state <= ST_OK;
            run   <= 8'd0;
        end else if (cmp_en) begin
            case (state)
                ST_OK: begin
                    if (mismatch_p0) begin
                        if (THRESH8 <= 8'd1) begin
                            state <= ST_ERROR;
                        end else begin
                            state <= ST_SUSPECT;
                            run   <= 8'd1;
                        end
                    end
                end
                ST_SUSPECT: begin
                    if (!mismatch_p0) begin
                        state <= ST_OK;
                        run   <= 8'd0;
                    end else if (run_next >= THRESH8) begin
                        state <= ST_ERROR;
                        run   <= run_next;
                    end else begin
                        run   <= run_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (clear_req) cnt <= '0;
        else if (cmp_en && mismatch_p0 && (cnt != CNT_MAX)) cnt <= cnt + CNT_W'(1);
    end

    assign DLS_ERROR = (state == ST_ERROR) & (inject_bug != INJ_MASK_ERR);
    assign HREADYOUT = 1'b1;

    always_comb begin
        HRDATA = '0;
        if (rd_q) begin
            case (addr_q)
                REG_STATUS: begin
                    HRDATA[0]              = (state == ST_ERROR);
                    HRDATA[1]              = (state == ST_SUSPECT);
                    HRDATA[NUM_REPL+1:2]   = mask_p1;
                end
                REG_COUNT: HRDATA = 32'(cnt);
                REG_CTRL:  HRDATA[1] = cmp_en;
                default:   HRDATA = '0;
            endcase
        end
    end

endmodule
